// File: rtl/mean_rev_engine.sv
// rtl/mean_rev_engine.sv - mean-reversion band signal engine with confirmation and cooldown
// Optional stop-loss exit is enabled by defining MEAN_REV_STOP_EN.
module mean_rev_engine #(
  parameter int WIDTH    = 8,
  parameter int CONFIRM  = 2,
  parameter int COOLDOWN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] short_sma,
  input  logic [WIDTH-1:0] long_sma,
  input  logic [WIDTH-1:0] current_data,
  input  logic [WIDTH-1:0] threshold,
  output logic             buy_signal,
  output logic             sell_signal,
  output logic [1:0]       position,
  output logic             stop_hit
);

  typedef enum logic [1:0] {
    ST_FLAT  = 2'b00,
    ST_LONG  = 2'b01,
    ST_SHORT = 2'b10,
    ST_COOL  = 2'b11
  } state_t;

  localparam logic [WIDTH+1:0] MAX_VAL = {2'b00, {WIDTH{1'b1}}};
  localparam logic [3:0]       CONF    = 4'(CONFIRM);
  localparam logic [7:0]       CD_LOAD = 8'(COOLDOWN - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n, cnt_inc;
  logic       dir, dir_n;
  logic [7:0] timer, timer_n;
  logic       buy_n, sell_n, buy_conf, sell_conf;
  logic       stop_exit;

  // Band around the midpoint of the two averages, kept one/two bits wide to avoid wrap.
  logic [WIDTH:0]   sma_sum, mid, lower;
  logic [WIDTH+1:0] upper_raw, upper;
  logic             trend, buy_cand, sell_cand;

  assign sma_sum   = {1'b0, short_sma} + {1'b0, long_sma};
  assign mid       = sma_sum >> 1;
  assign upper_raw = {1'b0, mid} + {2'b00, threshold};
  assign upper     = (upper_raw > MAX_VAL) ? MAX_VAL : upper_raw;
  assign lower     = (mid > {1'b0, threshold}) ? (mid - {1'b0, threshold}) : '0;
  assign trend     = short_sma > long_sma;
  assign buy_cand  = in_valid & trend & ({1'b0, current_data} < lower);
  assign sell_cand = in_valid & ~trend & ({2'b00, current_data} > upper);

`ifdef MEAN_REV_STOP_EN
  logic [WIDTH-1:0] entry;
  logic [WIDTH:0]   thr2, stop_lo;
  logic [WIDTH+1:0] stop_hi_raw, stop_hi;

  assign thr2        = {threshold, 1'b0};
  assign stop_lo     = ({1'b0, entry} > thr2) ? ({1'b0, entry} - thr2) : '0;
  assign stop_hi_raw = {2'b00, entry} + {1'b0, thr2};
  assign stop_hi     = (stop_hi_raw > MAX_VAL) ? MAX_VAL : stop_hi_raw;
  assign stop_exit   = in_valid &
                       (((state == ST_LONG)  & ({1'b0, current_data} < stop_lo)) |
                        ((state == ST_SHORT) & ({2'b00, current_data} > stop_hi)));

  always_ff @(posedge clk) begin
    if (rst) begin
      entry    <= '0;
      stop_hit <= 1'b0;
    end else begin
      stop_hit <= stop_exit;
      if (state == ST_FLAT && (state_n == ST_LONG || state_n == ST_SHORT))
        entry <= current_data;
    end
  end
`else
  assign stop_exit = 1'b0;
  assign stop_hit  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FLAT;
      cnt         <= '0;
      dir         <= 1'b0;
      timer       <= '0;
      buy_signal  <= 1'b0;
      sell_signal <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      dir         <= dir_n;
      timer       <= timer_n;
      buy_signal  <= buy_n;
      sell_signal <= sell_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dir_n     = dir;
    timer_n   = timer;
    cnt_inc   = cnt;
    buy_n     = 1'b0;
    sell_n    = 1'b0;
    buy_conf  = 1'b0;
    sell_conf = 1'b0;

    // dir: 0 = buy side, 1 = sell side
    if (state == ST_COOL) begin
      cnt_n = '0;
      if (timer == '0) state_n = ST_FLAT;
      else             timer_n = timer - 8'd1;
    end else if (in_valid) begin
      if (buy_cand || sell_cand) begin
        if (cnt != '0 && dir == sell_cand) begin
          cnt_inc = (cnt >= CONF) ? CONF : cnt + 4'd1;
        end else begin
          cnt_inc = 4'd1;
          dir_n   = sell_cand;
        end
        if (cnt_inc == CONF) begin
          cnt_n     = '0;
          buy_conf  = ~sell_cand;
          sell_conf = sell_cand;
        end else begin
          cnt_n = cnt_inc;
        end
      end else begin
        cnt_n = '0;
      end
    end

    if (stop_exit) begin
      state_n = ST_COOL;
      timer_n = CD_LOAD;
      cnt_n   = '0;
      sell_n  = (state == ST_LONG);
      buy_n   = (state == ST_SHORT);
    end else begin
      case (state)
        ST_FLAT: begin
          if (buy_conf) begin
            state_n = ST_LONG;
            buy_n   = 1'b1;
          end else if (sell_conf) begin
            state_n = ST_SHORT;
            sell_n  = 1'b1;
          end
        end
        ST_LONG: begin
          if (sell_conf) begin
            state_n = ST_COOL;
            timer_n = CD_LOAD;
            sell_n  = 1'b1;
          end
        end
        ST_SHORT: begin
          if (buy_conf) begin
            state_n = ST_COOL;
            timer_n = CD_LOAD;
            buy_n   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign position = state;

endmodule

// File: tb/tb_mean_rev_engine.sv
// tb/tb_mean_rev_engine.sv - self-checking bench for mean_rev_engine against a behavioural model
module tb_mean_rev_engine;

  localparam int WIDTH    = 8;
  localparam int CONFIRM  = 2;
  localparam int COOLDOWN = 4;
  localparam int MAXV     = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] short_sma = '0, long_sma = '0, current_data = '0, threshold = '0;
  logic             buy_signal, sell_signal, stop_hit;
  logic [1:0]       position;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mean_rev_engine #(.WIDTH(WIDTH), .CONFIRM(CONFIRM), .COOLDOWN(COOLDOWN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .short_sma(short_sma), .long_sma(long_sma), .current_data(current_data),
    .threshold(threshold), .buy_signal(buy_signal), .sell_signal(sell_signal),
    .position(position), .stop_hit(stop_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pos;
    int streak;
    int sdir;
    int cd_left;
    int entry;
    bit buy;
    bit sell;
    bit stop;
  } model_t;

  model_t m = '{0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};

  // pos: 0 flat, 1 long, 2 short, 3 cooldown; cd_left counts cooldown cycles remaining
  function automatic model_t model_step(model_t c, bit r, bit v, int s, int l, int d, int t);
    model_t n;
    int mid, upper, lower, conf, stop_hi;
    bit trend, bc, sc, stop;
    n = c;
    n.buy = 1'b0; n.sell = 1'b0; n.stop = 1'b0;
    if (r) begin
      n.pos = 0; n.streak = 0; n.sdir = 0; n.cd_left = 0; n.entry = 0;
      return n;
    end
    mid   = (s + l) / 2;
    upper = (mid + t > MAXV) ? MAXV : mid + t;
    lower = (mid > t) ? mid - t : 0;
    trend = s > l;
    bc = v && trend && (d < lower);
    sc = v && !trend && (d > upper);
    if (c.pos == 3) begin
      n.streak  = 0;
      n.cd_left = c.cd_left - 1;
      if (n.cd_left == 0) n.pos = 0;
      return n;
    end
    conf = -1;
    if (v) begin
      if (bc || sc) begin
        if (c.streak > 0 && c.sdir == int'(sc)) n.streak = c.streak + 1;
        else begin n.streak = 1; n.sdir = int'(sc); end
        if (n.streak >= CONFIRM) begin conf = n.sdir; n.streak = 0; end
      end else begin
        n.streak = 0;
      end
    end
    stop = 1'b0;
    stop_hi = (c.entry + 2 * t > MAXV) ? MAXV : c.entry + 2 * t;
`ifdef MEAN_REV_STOP_EN
    if (v && c.pos == 1 && d < c.entry - 2 * t) stop = 1'b1;
    if (v && c.pos == 2 && d > stop_hi) stop = 1'b1;
`endif
    if (stop) begin
      n.stop = 1'b1; n.sell = (c.pos == 1); n.buy = (c.pos == 2);
      n.pos = 3; n.cd_left = COOLDOWN; n.streak = 0;
    end else if (c.pos == 0 && conf == 0) begin
      n.pos = 1; n.buy = 1'b1; n.entry = d;
    end else if (c.pos == 0 && conf == 1) begin
      n.pos = 2; n.sell = 1'b1; n.entry = d;
    end else if (c.pos == 1 && conf == 1) begin
      n.pos = 3; n.sell = 1'b1; n.cd_left = COOLDOWN;
    end else if (c.pos == 2 && conf == 0) begin
      n.pos = 3; n.buy = 1'b1; n.cd_left = COOLDOWN;
    end
    return n;
  endfunction

  always @(posedge clk)
    m <= model_step(m, rst, in_valid, int'(short_sma), int'(long_sma),
                    int'(current_data), int'(threshold));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_position", int'(position), m.pos);
      chk("model_buy", int'(buy_signal), int'(m.buy));
      chk("model_sell", int'(sell_signal), int'(m.sell));
      chk("model_stop", int'(stop_hit), int'(m.stop));
      chk("no_dual_pulse", int'(buy_signal & sell_signal), 0);
    end
  end

  task automatic step(input bit r, input bit v, input int s, input int l, input int d, input int t);
    rst = r; in_valid = v;
    short_sma = 8'(s); long_sma = 8'(l); current_data = 8'(d); threshold = 8'(t);
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string tag, input int buy, input int sell, input int pos);
    chk({tag, "_buy"}, int'(buy_signal), buy);
    chk({tag, "_sell"}, int'(sell_signal), sell);
    chk({tag, "_pos"}, int'(position), pos);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    lit("reset", 0, 0, 0);
    chk("reset_stop", int'(stop_hit), 0);

    // basic entry: mid 105, lower 100, data 90 is a buy candidate
    step(0, 1, 110, 100, 90, 5);  lit("entry_first", 0, 0, 0);
    step(0, 1, 110, 100, 90, 5);  lit("entry_fire", 1, 0, 1);
    step(0, 0, 110, 100, 90, 5);  lit("entry_after", 0, 0, 1);
    step(0, 1, 110, 100, 90, 5);
    step(0, 1, 110, 100, 90, 5);  lit("no_pyramid", 0, 0, 1);

    // exit: mid 105, upper 110, data 120 is a sell candidate
    step(0, 1, 100, 110, 120, 5);
    step(0, 1, 100, 110, 120, 5); lit("exit_fire", 0, 1, 3);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 110, 100, 90, 5); lit("cooldown_hold", 0, 0, 3);
    end
    step(0, 1, 110, 100, 90, 5);  lit("cooldown_done", 0, 0, 0);

    // interrupted confirmation
    step(0, 1, 110, 100, 90, 5);
    step(0, 1, 110, 100, 105, 5);
    step(0, 1, 110, 100, 90, 5);  lit("interrupted", 0, 0, 0);
    step(0, 1, 110, 100, 90, 5);  lit("interrupted_then_fire", 1, 0, 1);

    // reset during cooldown cycle 2
    step(0, 1, 100, 110, 120, 5);
    step(0, 1, 100, 110, 120, 5); lit("exit2_fire", 0, 1, 3);
    step(0, 0, 0, 0, 0, 0);       lit("cool2", 0, 0, 3);
    step(1, 0, 0, 0, 0, 0);       lit("rst_in_cool", 0, 0, 0);
    chk("rst_in_cool_stop", int'(stop_hit), 0);

    // fresh count after reset, and invalid cycle holds the count
    step(0, 1, 110, 100, 90, 5);  lit("fresh_first", 0, 0, 0);
    step(0, 0, 110, 100, 90, 5);
    step(0, 1, 110, 100, 90, 5);  lit("hold_fire", 1, 0, 1);

    // reset mid-confirmation
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 110, 100, 90, 5);
    step(1, 1, 110, 100, 90, 5);
    step(0, 1, 110, 100, 90, 5);  lit("rst_mid_confirm", 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // opposite direction restarts the count; short entry and exit
    step(0, 1, 110, 100, 90, 5);
    step(0, 1, 100, 110, 120, 5); lit("dir_flip", 0, 0, 0);
    step(0, 1, 100, 110, 120, 5); lit("short_fire", 0, 1, 2);
    step(0, 1, 100, 110, 120, 5);
    step(0, 1, 100, 110, 120, 5); lit("short_no_pyramid", 0, 0, 2);
    step(0, 1, 110, 100, 90, 5);
    step(0, 1, 110, 100, 90, 5);  lit("short_exit", 1, 0, 3);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    lit("short_cool_done", 0, 0, 0);

    // saturation: mid 245, upper clamps to 255 so 255 never exceeds it
    repeat (4) step(0, 1, 250, 240, 255, 20);
    lit("ovf_up_trend", 0, 0, 0);
    repeat (4) step(0, 1, 240, 250, 255, 20);
    lit("ovf_down_trend", 0, 0, 0);
    // floor: lower = 0 when mid <= threshold; equality at upper is not a candidate
    repeat (2) step(0, 1, 10, 0, 0, 20);
    lit("lower_floor", 0, 0, 0);
    repeat (2) step(0, 1, 100, 110, 110, 5);
    lit("upper_equal", 0, 0, 0);

    // stop-loss: entry 90, threshold 5 gives stop level 80
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 110, 100, 90, 5);
    step(0, 1, 110, 100, 90, 5);  lit("stop_entry", 1, 0, 1);
    step(0, 1, 110, 100, 80, 5);  lit("stop_edge", 0, 0, 1);
    step(0, 1, 110, 100, 79, 5);
`ifdef MEAN_REV_STOP_EN
    lit("stop_exit", 0, 1, 3);
    chk("stop_exit_hit", int'(stop_hit), 1);
`else
    lit("stop_disabled", 0, 0, 1);
    chk("stop_disabled_hit", int'(stop_hit), 0);
`endif
    repeat (6) step(0, 0, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
